// File: rtl/pbkdf2_pkg.sv
// -----------------------------------------------------------------------------
// pbkdf2_pkg
// Shared types and constants for the PBKDF2 datapath blocks (the iteration
// accumulator and the salt||INT(i) packer).
//   DATA_W              : width of every HMAC key / message / result word
//   pbkdf2_iter_state_e : control states of the iteration accumulator
// -----------------------------------------------------------------------------
package pbkdf2_pkg;

  localparam int DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } pbkdf2_iter_state_e;

endpackage : pbkdf2_pkg

// File: rtl/pbkdf2_iter_acc.sv
// -----------------------------------------------------------------------------
// pbkdf2_iter_acc
// PBKDF2 F-function iteration engine wrapped around hmac_sha256. One job
// computes T = U_1 ^ ... ^ U_c where U_1 = HMAC(P, msg) and
// U_k = HMAC(P, U_{k-1}).
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   v_i / r_o             : job handshake (password_i, msg_i, iter_i)
//   hmac_v_o / hmac_r_i   : request to hmac_sha256 (hmac_prf_o key, hmac_salt_o msg)
//   hmac_v_i / hmac_r_o   : result from hmac_sha256 (hmac_prf_i = U_k)
//   v_o / r_i             : derived block handshake (dk_o = T)
//
// Every output is decoded from the state register and held data registers,
// so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module pbkdf2_iter_acc #(
  parameter int ITER_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              v_i,
  output logic              r_o,
  input  logic [DATA_W-1:0] password_i,
  input  logic [DATA_W-1:0] msg_i,
  input  logic [ITER_W-1:0] iter_i,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  output logic [DATA_W-1:0] hmac_prf_o,
  output logic [DATA_W-1:0] hmac_salt_o,
  input  logic              hmac_v_i,
  output logic              hmac_r_o,
  input  logic [DATA_W-1:0] hmac_prf_i,
  output logic              v_o,
  input  logic              r_i,
  output logic [DATA_W-1:0] dk_o
);

  import pbkdf2_pkg::*;

  localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
  localparam logic [ITER_W-1:0] ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  pbkdf2_iter_state_e state_q, state_d;
  logic [DATA_W-1:0]  key_q,   key_d;
  logic [DATA_W-1:0]  salt_q,  salt_d;
  logic [DATA_W-1:0]  acc_q,   acc_d;
  logic [DATA_W-1:0]  dk_q,    dk_d;
  logic [ITER_W-1:0]  cnt_q,   cnt_d;
  logic [ITER_W-1:0]  tgt_q,   tgt_d;

  // Next-state and datapath update for the iteration FSM.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    salt_d  = salt_q;
    acc_d   = acc_q;
    dk_d    = dk_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;

    case (state_q)
      IDLE: begin
        if (v_i) begin
          key_d   = password_i;
          salt_d  = msg_i;
          acc_d   = DATA_ZERO;
          cnt_d   = ITER_ONE;
          // A zero iteration count still produces U_1.
          tgt_d   = (iter_i == ITER_ZERO) ? ITER_ONE : iter_i;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (hmac_r_i) begin
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end

      WAIT: begin
        if (hmac_v_i) begin
          acc_d = acc_q ^ hmac_prf_i;
          // Compare before incrementing so cnt never passes tgt and never wraps.
          if (cnt_q == tgt_q) begin
            dk_d    = acc_q ^ hmac_prf_i;
            state_d = DONE;
          end else begin
            salt_d  = hmac_prf_i;
            cnt_d   = cnt_q + ITER_ONE;
            state_d = ISSUE;
          end
        end else begin
          state_d = WAIT;
        end
      end

      DONE: begin
        if (r_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= DATA_ZERO;
      salt_q  <= DATA_ZERO;
      acc_q   <= DATA_ZERO;
      dk_q    <= DATA_ZERO;
      cnt_q   <= ITER_ZERO;
      tgt_q   <= ITER_ZERO;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      salt_q  <= salt_d;
      acc_q   <= acc_d;
      dk_q    <= dk_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Output decode from state; data buses read zero outside their owning state.
  always_comb begin
    r_o         = 1'b0;
    hmac_v_o    = 1'b0;
    hmac_r_o    = 1'b0;
    v_o         = 1'b0;
    hmac_prf_o  = DATA_ZERO;
    hmac_salt_o = DATA_ZERO;
    dk_o        = DATA_ZERO;

    case (state_q)
      IDLE: begin
        r_o = 1'b1;
      end
      ISSUE: begin
        hmac_v_o    = 1'b1;
        hmac_prf_o  = key_q;
        hmac_salt_o = salt_q;
      end
      WAIT: begin
        hmac_r_o = 1'b1;
      end
      DONE: begin
        v_o  = 1'b1;
        dk_o = dk_q;
      end
      default: begin
        r_o = 1'b0;
      end
    endcase
  end

endmodule : pbkdf2_iter_acc

// File: tb/tb_pbkdf2_iter_acc.sv
// -----------------------------------------------------------------------------
// tb_pbkdf2_iter_acc
// Directed bench for pbkdf2_iter_acc with an HMAC stand-in whose result is
// U = key ^ msg after a programmable number of cycles.
// -----------------------------------------------------------------------------
module tb_pbkdf2_iter_acc;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         v_i;
  logic         r_o;
  logic [255:0] password_i;
  logic [255:0] msg_i;
  logic [31:0]  iter_i;
  logic         hmac_v_o;
  logic         hmac_r_i;
  logic [255:0] hmac_prf_o;
  logic [255:0] hmac_salt_o;
  logic         hmac_v_i;
  logic         hmac_r_o;
  logic [255:0] hmac_prf_i;
  logic         v_o;
  logic         r_i;
  logic [255:0] dk_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  pbkdf2_iter_acc #(.ITER_W(32), .DATA_W(256)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .v_i         (v_i),
    .r_o         (r_o),
    .password_i  (password_i),
    .msg_i       (msg_i),
    .iter_i      (iter_i),
    .hmac_v_o    (hmac_v_o),
    .hmac_r_i    (hmac_r_i),
    .hmac_prf_o  (hmac_prf_o),
    .hmac_salt_o (hmac_salt_o),
    .hmac_v_i    (hmac_v_i),
    .hmac_r_o    (hmac_r_o),
    .hmac_prf_i  (hmac_prf_i),
    .v_o         (v_o),
    .r_i         (r_i),
    .dk_o        (dk_o)
  );

  // ---------------- HMAC stand-in: U = prf ^ salt after stub_lat cycles -----
  int           stub_lat = 3;
  logic         hmac_gate;
  logic         stub_busy = 1'b0;
  logic         stub_v    = 1'b0;
  int           stub_dly  = 0;
  logic [255:0] stub_res  = '0;
  int           xfer_cnt  = 0;
  logic [255:0] salt_log [0:63];

  assign hmac_r_i   = hmac_gate & ~stub_busy & ~stub_v;
  assign hmac_v_i   = stub_v;
  assign hmac_prf_i = stub_res;

  // Stand-in request capture, latency countdown and result handshake.
  always @(posedge clk_i) begin
    if (rst_i) begin
      stub_busy <= 1'b0;
      stub_v    <= 1'b0;
      stub_dly  <= 0;
    end else begin
      if (stub_v && hmac_r_o) stub_v <= 1'b0;
      if (stub_busy) begin
        if (stub_dly <= 1) begin
          stub_v    <= 1'b1;
          stub_busy <= 1'b0;
        end else begin
          stub_dly <= stub_dly - 1;
        end
      end
      if (hmac_v_o && hmac_r_i) begin
        stub_busy              <= 1'b1;
        stub_dly               <= stub_lat;
        stub_res               <= hmac_prf_o ^ hmac_salt_o;
        salt_log[xfer_cnt % 64] <= hmac_salt_o;
        xfer_cnt               <= xfer_cnt + 1;
      end
    end
  end

  // ---------------- checking -------------------------------------------------
  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Run one job with r_i held high; checks result, latency and request count.
  task automatic do_job(input string tag, input logic [255:0] p, input logic [255:0] m,
                        input logic [31:0] c, input int lat, input logic [255:0] exp_t);
    int cyc;
    int start;
    int c_eff;
    c_eff = (c == 32'd0) ? 1 : int'(c);
    stub_lat = lat;
    start = xfer_cnt;
    check_eq({tag, "_r_o_idle"}, r_o, 1'b1);
    password_i = p; msg_i = m; iter_i = c; v_i = 1'b1; r_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    cyc = 1;
    while (!v_o && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check_eq({tag, "_v_o"}, v_o, 1'b1);
    check_eq({tag, "_latency"}, cyc, c_eff * (lat + 2) + 1);
    check_eq({tag, "_dk"}, dk_o, exp_t);
    check_eq({tag, "_n_req"}, xfer_cnt - start, c_eff);
    check_eq({tag, "_salt0"}, salt_log[start % 64], m);
    @(posedge clk_i); #1;
    check_eq({tag, "_v_o_drop"}, v_o, 1'b0);
    check_eq({tag, "_r_o_back"}, r_o, 1'b1);
  endtask

  localparam logic [255:0] P_AA = {32{8'hAA}};
  localparam logic [255:0] M_0F = {32{8'h0F}};
  localparam logic [255:0] T_A5 = {32{8'hA5}};
  localparam logic [255:0] T_AA = {32{8'hAA}};
  localparam logic [255:0] T_0F = {32{8'h0F}};
  localparam logic [255:0] P_3C = {32{8'h3C}};
  localparam logic [255:0] M_C3 = {32{8'hC3}};
  localparam logic [255:0] U_FF = {32{8'hFF}};
  localparam logic [255:0] P_33 = {32{8'h33}};
  localparam logic [255:0] M_5A = {32{8'h5A}};
  localparam logic [255:0] T_69 = {32{8'h69}};

  initial begin
    int cyc;
    int start;
    rst_i = 1'b1; v_i = 1'b0; r_i = 1'b1; hmac_gate = 1'b1;
    password_i = '0; msg_i = '0; iter_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_r_o",      r_o, 1'b1);
    check_eq("rst_hmac_v_o", hmac_v_o, 1'b0);
    check_eq("rst_hmac_r_o", hmac_r_o, 1'b0);
    check_eq("rst_v_o",      v_o, 1'b0);
    check_eq("rst_dk",       dk_o, '0);
    check_eq("rst_prf",      hmac_prf_o, '0);
    check_eq("rst_salt",     hmac_salt_o, '0);
    rst_i = 1'b0;

    // U1 = AA^0F = A5, U2 = AA^A5 = 0F, U3 = AA^0F = A5.
    do_job("c1", P_AA, M_0F, 32'd1, 3, T_A5);
    start = xfer_cnt;
    do_job("c2", P_AA, M_0F, 32'd2, 3, T_AA);
    check_eq("c2_salt1", salt_log[(start + 1) % 64], T_A5);
    do_job("c3", P_AA, M_0F, 32'd3, 3, T_0F);
    do_job("c0", P_AA, M_0F, 32'd0, 3, T_A5);

    // Backpressure: U1 = 3C^C3 = FF, U2 = 3C^FF = C3, T = FF^C3 = 3C.
    stub_lat = 1;
    start = xfer_cnt;
    hmac_gate = 1'b0; r_i = 1'b0;
    password_i = P_3C; msg_i = M_C3; iter_i = 32'd2; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_hmac_v_o", hmac_v_o, 1'b1);
      check_eq("bp_salt",     hmac_salt_o, M_C3);
      check_eq("bp_prf",      hmac_prf_o, P_3C);
      check_eq("bp_r_o",      r_o, 1'b0);
      @(posedge clk_i); #1;
    end
    hmac_gate = 1'b1;
    cyc = 0;
    while (!v_o && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_v_o",   v_o, 1'b1);
      check_eq("bp_dk",    dk_o, P_3C);
      check_eq("bp_r_o_d", r_o, 1'b0);
      @(posedge clk_i); #1;
    end
    check_eq("bp_salt1", salt_log[(start + 1) % 64], U_FF);
    check_eq("bp_n_req", xfer_cnt - start, 2);
    r_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("bp_v_o_drop", v_o, 1'b0);
    check_eq("bp_r_o_back", r_o, 1'b1);

    // Reset in WAIT of iteration 2 of a c=5 job.
    stub_lat = 2;
    start = xfer_cnt;
    password_i = P_AA; msg_i = M_0F; iter_i = 32'd5; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    cyc = 0;
    while (xfer_cnt - start < 2 && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check_eq("rw_n_req",    xfer_cnt - start, 2);
    check_eq("rw_in_wait",  hmac_r_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_eq("rw_r_o",      r_o, 1'b1);
    check_eq("rw_hmac_v_o", hmac_v_o, 1'b0);
    check_eq("rw_hmac_r_o", hmac_r_o, 1'b0);
    check_eq("rw_v_o",      v_o, 1'b0);
    check_eq("rw_dk",       dk_o, '0);
    check_eq("rw_prf",      hmac_prf_o, '0);
    check_eq("rw_salt",     hmac_salt_o, '0);

    // Fresh job after abort: 33^5A = 69, no leftover accumulator.
    do_job("post_rst", P_33, M_5A, 32'd1, 2, T_69);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_pbkdf2_iter_acc
